gshare_pattern_history_table: RTL

- Next-generation pattern history table for the branch predictor.
- Fully parametrised in table depth, counter width and global-history length.
- Table index = lookup PC bits XOR global history (gshare), with a speculative global history register (GHR) and restore on mispredict.
- Table storage has no per-entry reset; a sweep state machine initialises it after reset or on a clear request. Sits between fetch (lookup) and the branch resolution unit (update).

---
 rtl/gshare_pattern_history_table.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/gshare_pattern_history_table.sv
// gshare_pattern_history_table
//
// Pattern history table for the branch predictor. It holds 2**INDEX_LEN
// saturating counters, each COUNT_WIDTH bits wide. A counter is selected by
// XOR-ing the branch PC index bits with the global history, zero-extended
// to INDEX_LEN bits (gshare hashing). A speculative global history register
// (GHR) shifts in every prediction. A resolved mispredict restores the GHR
// from the history captured at prediction time, plus the actual outcome.
//
// The counter storage has no per-entry reset. After reset, and on a clear
// request, a sweep writes the weakly-not-taken value into every entry, one
// entry per cycle. While the sweep runs, ready is low, all outputs read
// zero, and lookups and updates are ignored.
//
// Build option:
//   GSHARE_PHT_FORWARD_EN - if defined, an update and a lookup that hit the
//                           same entry in the same cycle return the
//                           post-update value. If not defined, the lookup
//                           returns the stored value. The table write is the
//                           same in both builds.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   clear          one-cycle pulse; re-initialises the table and the GHR
//   lookup_valid   fetch is predicting a branch this cycle
//   lookup_pc      PC index bits of the branch being predicted
//   predict_taken  MSB of the selected counter
//   predict_count  raw value of the selected counter
//   ghr_out        GHR used by the current lookup
//   ready          table initialised; lookups and updates are honoured
//   upd_valid      a resolved branch is being written back
//   upd_pc         PC index bits of the resolved branch
//   upd_ghr        GHR captured when that branch was predicted
//   upd_taken      actual outcome of the branch
//   upd_mispredict the prediction was wrong; qualified by upd_valid

module gshare_pattern_history_table #(
    parameter int INDEX_LEN   = 10,
    parameter int COUNT_WIDTH = 2,
    parameter int HIST_LEN    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   lookup_valid,
    input  logic [INDEX_LEN-1:0]   lookup_pc,
    output logic                   predict_taken,
    output logic [COUNT_WIDTH-1:0] predict_count,
    output logic [HIST_LEN-1:0]    ghr_out,
    output logic                   ready,
    input  logic                   upd_valid,
    input  logic [INDEX_LEN-1:0]   upd_pc,
    input  logic [HIST_LEN-1:0]    upd_ghr,
    input  logic                   upd_taken,
    input  logic                   upd_mispredict
);

    localparam int DEPTH = 2 ** INDEX_LEN;

    typedef logic [COUNT_WIDTH-1:0] count_t;
    typedef logic [INDEX_LEN-1:0]   index_t;
    typedef logic [HIST_LEN-1:0]    hist_t;

    typedef enum logic {
        SWEEP,
        RUN
    } state_e;

    localparam count_t CNT_MAX  = '1;
    // Weakly not-taken value: 2**(COUNT_WIDTH-1)-1.
    localparam count_t CNT_INIT = CNT_MAX >> 1;
    localparam index_t PTR_LAST = '1;

    state_e state_q, state_d;
    index_t ptr_q,   ptr_d;
    hist_t  ghr_q,   ghr_d;

    count_t pht_q [DEPTH];

    logic   wr_en;
    index_t wr_idx;
    count_t wr_data;

    index_t lookup_idx;
    index_t upd_idx;
    count_t upd_old;
    count_t upd_count;
    count_t read_count;
    logic   upd_fire;

    assign ready      = (state_q == RUN);
    assign lookup_idx = lookup_pc ^ index_t'(ghr_q);
    assign upd_idx    = upd_pc ^ index_t'(upd_ghr);
    // A clear in the same cycle drops the update.
    assign upd_fire   = upd_valid && ready && !clear;

    // Next value of the counter selected by the update. It saturates at
    // both ends.
    always_comb begin
        upd_old   = pht_q[upd_idx];
        upd_count = upd_old;
        if (upd_taken) begin
            if (upd_old != CNT_MAX) upd_count = upd_old + count_t'(1);
        end else begin
            if (upd_old != '0) upd_count = upd_old - count_t'(1);
        end
    end

    always_comb begin
`ifdef GSHARE_PHT_FORWARD_EN
        if (upd_fire && (upd_idx == lookup_idx)) begin
            read_count = upd_count;
        end else begin
            read_count = pht_q[lookup_idx];
        end
`else
        read_count = pht_q[lookup_idx];
`endif
    end

    assign predict_count = ready ? read_count : '0;
    assign predict_taken = predict_count[COUNT_WIDTH-1];
    assign ghr_out       = ready ? ghr_q : '0;

    // NOTE: every signal written here gets a default value first. Without
    // the defaults, any branch that skips an assignment would infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_data = CNT_INIT;

        case (state_q)
            SWEEP: begin
                ghr_d = '0;
                if (clear) begin
                    ptr_d = '0;
                end else begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + index_t'(1);
                    if (ptr_q == PTR_LAST) state_d = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                    ghr_d   = '0;
                end else begin
                    if (upd_fire) begin
                        wr_en   = 1'b1;
                        wr_idx  = upd_idx;
                        wr_data = upd_count;
                    end
                    // A restore overrides a same-cycle speculative shift.
                    // Truncating the concatenation to HIST_LEN bits also
                    // covers HIST_LEN == 1.
                    if (upd_valid && upd_mispredict) begin
                        ghr_d = hist_t'({upd_ghr, upd_taken});
                    end else if (lookup_valid) begin
                        ghr_d = hist_t'({ghr_q, predict_taken});
                    end
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its pre-edge value, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    // NOTE: the table has no reset, so it can map onto RAM. The sweep above
    // gives it defined contents before ready rises.
    always_ff @(posedge clk) begin
        if (wr_en) pht_q[wr_idx] <= wr_data;
    end

endmodule
